// File: rtl/datamem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : datamem_arbiter
//  Purpose  : Two-port round-robin arbiter and access sequencer in front of a
//             single-port, word-addressed data memory (combinational read,
//             write on posedge clk). Requester 0 is the CPU load/store unit,
//             requester 1 is the loader/debug port. Sub-word stores are merged
//             with the current memory word, and misaligned or out-of-range
//             accesses are rejected before they reach the memory.
//  Ports    : clk, reset                  clock, async active-high reset
//             reqN_valid/ready            request handshake (N = 0, 1)
//             reqN_write/addr/wdata/wstrb request payload
//             rspN_valid/rdata/err        registered one-cycle response
//             mem_addr/write_enable/      memory-side interface
//             mem_data_in/mem_data
//  Revision : 1.0  initial release
// ============================================================================
module datamem_arbiter #(
  parameter int MEM_WORDS = 32,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_write,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic [3:0]  req0_wstrb,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_write,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  input  logic [3:0]  req1_wstrb,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data
);

  localparam logic [0:0]  c_st_idle    = 1'b0;
  localparam logic [0:0]  c_st_access  = 1'b1;
  // One bit wider than an address so 4*MEM_WORDS never wraps.
  localparam logic [32:0] c_addr_limit = 33'(4 * MEM_WORDS);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic             r_last_grant;
  logic             r_owner;
  logic             r_write;
  logic             r_err;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;

  logic             w_gnt0;
  logic             w_gnt1;
  logic             w_accept;
  logic             w_sel_write;
  logic [31:0]      w_sel_addr;
  logic [31:0]      w_sel_wdata;
  logic [3:0]       w_sel_wstrb;
  logic             w_addr_err;
  logic [31:0]      w_merged;
  logic [31:0]      w_rdata;

  // On a tie the requester that did not win last time is granted.
  assign w_gnt0   = req0_valid & (~req1_valid | r_last_grant);
  assign w_gnt1   = req1_valid & (~req0_valid | ~r_last_grant);
  assign w_accept = (r_state == c_st_idle) & (w_gnt0 | w_gnt1) & ~reset;

  assign w_sel_write = w_gnt1 ? req1_write : req0_write;
  assign w_sel_addr  = w_gnt1 ? req1_addr  : req0_addr;
  assign w_sel_wdata = w_gnt1 ? req1_wdata : req0_wdata;
  assign w_sel_wstrb = w_gnt1 ? req1_wstrb : req0_wstrb;
  assign w_addr_err  = (w_sel_addr[1:0] != 2'b00) | ({1'b0, w_sel_addr} >= c_addr_limit);

  // Rejected accesses return zero rather than whatever word sits at address 0.
  assign w_rdata = r_err ? 32'h0 : mem_data;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = r_wstrb[i] ? r_wdata[8*i +: 8] : mem_data[8*i +: 8];
    end
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:   if (w_accept) w_state_next = c_st_access;
      c_st_access: w_state_next = c_st_idle;
      default:     w_state_next = c_st_idle;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req0_ready       = 1'b0;
    req1_ready       = 1'b0;
    mem_addr         = 32'h0;
    mem_write_enable = 1'b0;
    mem_data_in      = 32'h0;
    case (r_state)
      c_st_idle: begin
        req0_ready = w_gnt0 & ~reset;
        req1_ready = w_gnt1 & ~reset;
      end
      c_st_access: begin
        // A rejected access is steered to address 0 and never writes.
        mem_addr         = r_err ? 32'h0 : 32'({r_idx, 2'b00});
        mem_write_enable = r_write & ~r_err & (|r_wstrb) & ~reset;
        mem_data_in      = w_merged;
      end
      default: ;
    endcase
  end

  // ---------------- Request capture ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_write      <= 1'b0;
      r_err        <= 1'b0;
      r_idx        <= '0;
      r_wdata      <= 32'h0;
      r_wstrb      <= 4'h0;
    end else if (w_accept) begin
      r_last_grant <= w_gnt1;
      r_owner      <= w_gnt1;
      r_write      <= w_sel_write;
      r_err        <= w_addr_err;
      r_idx        <= w_sel_addr[IDX_W+1:2];
      r_wdata      <= w_sel_wdata;
      r_wstrb      <= w_sel_wstrb;
    end
  end

  // ---------------- Responses ----------------
  // Data and error hold until the next response on the same port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp0_rdata <= 32'h0;
      rsp0_err   <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp1_rdata <= 32'h0;
      rsp1_err   <= 1'b0;
    end else begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (r_state == c_st_access) begin
        if (r_owner) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= w_rdata;
          rsp1_err   <= r_err;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= w_rdata;
          rsp0_err   <= r_err;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_datamem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_datamem_arbiter
//  Purpose  : Self-checking bench for datamem_arbiter with a 32-word memory
//             model. Single transactions come from a vector table; contention,
//             streaming and reset corner cases are hand-written sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_datamem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req0_write;
  logic [31:0] req0_addr, req0_wdata;
  logic [3:0]  req0_wstrb;
  logic        req1_valid, req1_ready, req1_write;
  logic [31:0] req1_addr, req1_wdata;
  logic [3:0]  req1_wstrb;
  logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [31:0] rsp0_rdata, rsp1_rdata;
  logic [31:0] mem_addr, mem_data_in, mem_data;
  logic        mem_write_enable;

  int checks = 0;
  int errors = 0;

  // Memory model with a bench-side preload port
  logic [31:0] mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = 5'd0;
  logic [31:0] pl_data = 32'h0;

  assign mem_data = mem[mem_addr[6:2]];

  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (mem_write_enable) mem[mem_addr[6:2]] <= mem_data_in;
  end

  always #5 clk = ~clk;

  datamem_arbiter #(.MEM_WORDS(32)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_addr(mem_addr), .mem_write_enable(mem_write_enable),
    .mem_data_in(mem_data_in), .mem_data(mem_data)
  );

  typedef struct {
    logic        port;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        pl;
    logic [4:0]  pl_i;
    logic [31:0] pl_d;
    logic        exp_we;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [4:0]  chk_idx;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] idx, input logic [31:0] d);
    pl_en = 1'b1; pl_idx = idx; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic set_req(input logic p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (p) begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d; req1_wstrb = s;
    end else begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d; req0_wstrb = s;
    end
  endtask

  task automatic run_vec(input vec_t v);
    if (v.pl) preload(v.pl_i, v.pl_d);
    set_req(v.port, 1'b1, v.write, v.addr, v.wdata, v.wstrb);
    #1;
    chk("ready_winner", v.port ? req1_ready : req0_ready, 1);
    chk("ready_other",  v.port ? req0_ready : req1_ready, 0);
    tick();
    // captured copy must be used: scramble the live inputs
    set_req(v.port, 1'b0, ~v.write, ~v.addr, ~v.wdata, ~v.wstrb);
    #1;
    chk("access_we", mem_write_enable, v.exp_we);
    chk("access_no_rsp", {rsp0_valid, rsp1_valid}, 0);
    tick();
    #1;
    chk("rsp_valid",  v.port ? rsp1_valid : rsp0_valid, 1);
    chk("rsp_other",  v.port ? rsp0_valid : rsp1_valid, 0);
    chk("rsp_rdata",  v.port ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
    chk("rsp_err",    v.port ? rsp1_err   : rsp0_err,   v.exp_err);
    chk("mem_word",   mem[v.chk_idx], v.exp_word);
    tick();
    chk("rsp_pulse_end", v.port ? rsp1_valid : rsp0_valid, 0);
    chk("rsp_hold",   v.port ? rsp1_rdata : rsp0_rdata, v.exp_rdata);
  endtask

  initial begin
    //          port wr  addr          wdata         strb   pl  idx   pl_data       we  rdata         err  chk  word
    vecs[0] = '{1'b0, 1'b0, 32'h0000000C, 32'h00000000, 4'h0, 1'b1, 5'd3,  32'h11223344, 1'b0, 32'h11223344, 1'b0, 5'd3,  32'h11223344};
    vecs[1] = '{1'b1, 1'b1, 32'h0000000C, 32'hAABBCCDD, 4'h5, 1'b0, 5'd0,  32'h0,        1'b1, 32'h11223344, 1'b0, 5'd3,  32'h11BB33DD};
    vecs[2] = '{1'b0, 1'b0, 32'h0000000C, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        1'b0, 32'h11BB33DD, 1'b0, 5'd3,  32'h11BB33DD};
    vecs[3] = '{1'b0, 1'b1, 32'h0000000E, 32'hFFFFFFFF, 4'hF, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00000000, 1'b1, 5'd3,  32'h11BB33DD};
    vecs[4] = '{1'b1, 1'b0, 32'h00000080, 32'h00000000, 4'h0, 1'b1, 5'd0,  32'h5A5A5A5A, 1'b0, 32'h00000000, 1'b1, 5'd0,  32'h5A5A5A5A};
    vecs[5] = '{1'b1, 1'b1, 32'h0000007C, 32'h12345678, 4'hF, 1'b1, 5'd31, 32'h0F0F0F0F, 1'b1, 32'h0F0F0F0F, 1'b0, 5'd31, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 32'h00000014, 32'h00000000, 4'h0, 1'b1, 5'd5,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 5'd5,  32'hCAFEF00D};
    vecs[7] = '{1'b1, 1'b0, 32'h0000007C, 32'hDEADDEAD, 4'hF, 1'b0, 5'd0,  32'h0,        1'b0, 32'h12345678, 1'b0, 5'd31, 32'h12345678};
    vecs[8] = '{1'b0, 1'b1, 32'h00000004, 32'hA5FFFFFF, 4'h8, 1'b1, 5'd1,  32'h00000000, 1'b1, 32'h00000000, 1'b0, 5'd1,  32'hA5000000};
    vecs[9] = '{1'b0, 1'b1, 32'hFFFFFFFC, 32'h00000001, 4'hF, 1'b0, 5'd0,  32'h0,        1'b0, 32'h00000000, 1'b1, 5'd31, 32'h12345678};

    // Reset state; valids high to confirm readies are forced low
    reset = 1'b1;
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_rsp_valid", {rsp0_valid, rsp1_valid}, 0);
    chk("rst_rsp0", {rsp0_err, rsp0_rdata}, 0);
    chk("rst_rsp1", {rsp1_err, rsp1_rdata}, 0);
    chk("rst_mem_out", {mem_write_enable, mem_addr, mem_data_in} != 0, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Contention: both valid continuously, grant order 0,1,0,1...
    preload(5'd10, 32'hA0A0A0A0);
    preload(5'd11, 32'hB1B1B1B1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'h28, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h2C, 32'h0, 4'h0);
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk("cont_ready0", req0_ready, ((c / 2) % 2) == 0);
        chk("cont_ready1", req1_ready, ((c / 2) % 2) == 1);
      end else begin
        chk("cont_ready_access", {req0_ready, req1_ready}, 0);
      end
      if (c % 2 == 0 && c >= 2) begin
        chk("cont_rsp0", rsp0_valid, (((c / 2) - 1) % 2) == 0);
        chk("cont_rsp1", rsp1_valid, (((c / 2) - 1) % 2) == 1);
        chk("cont_rdata", rsp0_valid ? rsp0_rdata : rsp1_rdata,
            ((((c / 2) - 1) % 2) == 0) ? 32'hA0A0A0A0 : 32'hB1B1B1B1);
      end else begin
        chk("cont_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      end
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("cont_last_rsp", {rsp0_valid, rsp1_valid}, 2'b01);
    tick();

    // Streaming: req0 issues 8 back-to-back stores, req1 idle
    for (int k = 0; k < 8; k++) preload(5'(8 + k), 32'h100 + k);
    set_req(1'b0, 1'b1, 1'b1, 32'h20, 32'hB0000000, 4'hF);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("strm_ready", req0_ready, 1);
      if (k > 0) begin
        chk("strm_rsp", rsp0_valid, 1);
        chk("strm_rdata", rsp0_rdata, 32'h100 + k - 1);
      end
      tick();
      if (k < 7) set_req(1'b0, 1'b1, 1'b1, 32'((8 + k + 1) * 4), 32'hB0000000 + k + 1, 4'hF);
      else       set_req(1'b0, 1'b0, 1'b0, 32'hFFFFFFF0, 32'h0, 4'h0);
      #1;
      chk("strm_access_ready", req0_ready, 0);
      chk("strm_we", mem_write_enable, 1);
      tick();
    end
    #1;
    chk("strm_last_rsp", rsp0_valid, 1);
    chk("strm_last_rdata", rsp0_rdata, 32'h107);
    for (int k = 0; k < 8; k++) chk("strm_mem", mem[8 + k], 32'hB0000000 + k);
    tick();

    // Reset during ACCESS discards the pending store
    preload(5'd4, 32'h44444444);
    set_req(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    #1;
    chk("rma_ready", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    #1;
    chk("rma_we_before", mem_write_enable, 1);
    reset = 1'b1;
    #1;
    chk("rma_we_dropped", mem_write_enable, 0);
    tick();
    chk("rma_no_rsp", rsp0_valid, 0);
    chk("rma_mem_kept", mem[4], 32'h44444444);
    reset = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("rma_tie_ready0", req0_ready, 1);
    chk("rma_tie_ready1", req1_ready, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    tick();
    chk("rma_idle_rsp", {rsp0_valid, rsp1_valid}, 0);

    // Reset during the response pulse clears it at once
    set_req(1'b1, 1'b1, 1'b0, 32'h7C, 32'h0, 4'h0);
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    chk("rrsp_pulse", rsp1_valid, 1);
    reset = 1'b1;
    #1;
    chk("rrsp_cleared", rsp1_valid, 0);
    chk("rrsp_rdata_cleared", rsp1_rdata, 0);
    tick();
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
